arr_drain_16: RTL and testbench
===============================

# arr_drain_16

Output-side counterpart of the 16x16 array controller: collects the skewed per-lane results leaving the systolic array, re-quantizes each 16-bit result to a signed byte, and serializes the bytes onto a valid/ready output stream. Where the input side skews operands into the array (lane i delayed i cycles), this block deskews the results by capturing each lane independently into a register bank, then drains the bank in lane order. It sits between the PE-array result edge and the off-chip/output-memory byte interface.

## Interface
- LANES, 16, number of result lanes (array columns)
- RLEN, 16, result width per lane (signed two's complement)
- WORDLEN, 8, output word width (signed)
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- enable  in  1  global advance; low freezes FSM, counters, and outputs (captures ignored)
- start  in  1  one-cycle pulse opening a drain batch; honored only in IDLE
- num_lanes  in  5  lanes valid in this batch (0..16; values >16 clamp to 16); sampled at start
- shift  in  4  arithmetic right-shift for re-quantization; sampled at start
- res_in  in  LANES*RLEN  lane i result at bits [i*RLEN +: RLEN]
- res_valid  in  LANES  per-lane result strobe
- out_data  out  WORDLEN  serialized re-quantized result
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- busy  out  1  high in CAPTURE or SEND
- done  out  1  one-cycle pulse at batch end
- ovf  out  1  sticky: a lane strobed twice in one batch; cleared by reset or next start

## Operation
- States: IDLE, CAPTURE, SEND, FIN.
- IDLE: start && enable -> latch n = min(num_lanes,16), sh = shift; clear captured mask, ovf; if n==0 -> FIN else -> CAPTURE.
- CAPTURE: for each lane i<n with res_valid[i]: store res_in lane i into bank[i], set captured[i]. Strobes on lanes >= n ignored. Strobe on an already-captured lane: bank not overwritten, ovf set. When captured[n-1:0] all ones (including captures made this cycle) -> SEND next cycle, lane pointer p=0.
- SEND: out_data = sat8(bank[p] >>> sh), out_valid=1. On out_valid && out_ready: if p==n-1 -> FIN else p<=p+1. res_valid ignored in SEND.
- FIN: done=1 for one cycle -> IDLE.
- sat8: arithmetic shift of signed RLEN value, then clamp to [-128,127]; no rounding.
- enable low: state, p, bank, mask, out_data/out_valid held; out_ready handshake not counted.
- start outside IDLE ignored.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0, ovf=0, state IDLE, p=0, mask=0, bank=0.
- start at cycle t -> busy=1 from t+1.
- Last lane captured at edge t -> out_valid=1 with lane 0 from t+1.
- One byte per cycle when out_ready held high: n bytes occupy n cycles; done pulses the cycle after the last handshake; busy low same cycle as done.
- out_data/out_valid registered; stable while out_valid && !out_ready.
- Reset mid-batch: everything returns to reset values next edge; no done pulse.
- Typical skewed array output (lane i strobed at t0+i, n=16): first byte at t0+16, done at t0+32.

## Structure
- Package arr_pkg: LANES, RLEN, WORDLEN constants; drain state enum (IDLE, CAPTURE, SEND, FIN).
- Sub-module requant_sat: combinational signed RLEN -> WORDLEN arithmetic shift + saturate, parameterized by RLEN/WORDLEN; instantiated once on the muxed bank[p].

## Test plan
- Skewed full batch: n=16, sh=0, lane i = i-8 strobed at t0+i, out_ready=1 -> bytes -8..7 in order on consecutive cycles, done once, ovf=0.
- Saturation/shift: n=2, sh=4, lanes 0x7FFF, 0x8000 -> out 127, -128; sh=4 lane 0x0150 -> 21, lane 0xFEB0 -> -21.
- Backpressure: n=4, out_ready toggled 1,0,0,1,... -> out_data held stable during stalls, exactly 4 handshakes, done after 4th.
- Partial/duplicate: n=3, strobe lane 5 and lane 1 twice -> lane 5 ignored, first lane-1 value kept, ovf=1, exactly 3 bytes.
- n=0 and n=20: n=0 -> done at start+1, no out_valid; n=20 -> treated as 16 bytes.
- Reset mid-SEND after 2 bytes -> out_valid=0, busy=0, no done; fresh start then completes normally.

Source files
------------

// File: rtl/arr_drain_16_pkg.sv
// Shared constants, drain FSM state type and batch configuration payload
// for the systolic-array result drain.
package arr_pkg;

  localparam int unsigned LANES   = 16;
  localparam int unsigned RLEN    = 16;
  localparam int unsigned WORDLEN = 8;
  localparam int unsigned NW      = 5;   // num_lanes width (0..16 plus clamp headroom)
  localparam int unsigned SHW     = 4;   // shift amount width
  localparam int unsigned PW      = 4;   // lane pointer width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    FIN     = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic [NW-1:0]  n;
    logic [SHW-1:0] sh;
  } batch_cfg_t;

  // Low n lanes set: the lanes that participate in the current batch.
  function automatic logic [LANES-1:0] lane_mask(input logic [NW-1:0] n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      m[i] = (NW'(i) < n);
    end
    return m;
  endfunction

  function automatic logic [NW-1:0] clamp_lanes(input logic [NW-1:0] n);
    return (n > NW'(LANES)) ? NW'(LANES) : n;
  endfunction

endpackage

// File: rtl/arr_drain_16_if.sv
// Byte output stream (valid/ready) leaving the result drain.
interface arr_drain_16_if;
  import arr_pkg::*;

  logic [WORDLEN-1:0] data;
  logic               valid;
  logic               ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/arr_drain_16_requant_sat.sv
// Re-quantizer: arithmetic right shift of a signed result, then clamp to
// the signed output word range (truncating, no rounding).
module requant_sat
  import arr_pkg::*;
#(
  parameter int unsigned RLEN    = arr_pkg::RLEN,
  parameter int unsigned WORDLEN = arr_pkg::WORDLEN,
  parameter int unsigned SHW     = arr_pkg::SHW
) (
  input  logic [RLEN-1:0]    din,
  input  logic [SHW-1:0]     sh,
  output logic [WORDLEN-1:0] q_c
);

  localparam logic signed [RLEN-1:0] MAX_V = RLEN'((1 << (WORDLEN - 1)) - 1);
  localparam logic signed [RLEN-1:0] MIN_V = ~MAX_V;

  logic signed [RLEN-1:0] shifted;

  always_comb begin
    shifted = $signed(din) >>> sh;
    if (shifted > MAX_V) begin
      q_c = MAX_V[WORDLEN-1:0];
    end else if (shifted < MIN_V) begin
      q_c = MIN_V[WORDLEN-1:0];
    end else begin
      q_c = shifted[WORDLEN-1:0];
    end
  end

endmodule

// File: rtl/arr_drain_16.sv
// Result drain for the 16x16 array: deskews per-lane results into a bank,
// then streams re-quantized bytes out in lane order.
module arr_drain_16
  import arr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  start,
  input  logic [NW-1:0]         num_lanes,
  input  logic [SHW-1:0]        shift,
  input  logic [LANES*RLEN-1:0] res_in,
  input  logic [LANES-1:0]      res_valid,
  arr_drain_16_if.master        stream,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  drain_state_e                 state, state_nxt;
  batch_cfg_t                   cfg, cfg_nxt;
  logic [LANES-1:0][RLEN-1:0]   bank, bank_nxt;
  logic [LANES-1:0]             mask, mask_nxt;
  logic [LANES-1:0]             need;
  logic [PW-1:0]                p, p_nxt;
  logic                         ovf_nxt;
  logic                         valid_q, valid_nxt;
  logic [WORDLEN-1:0]           data_q, data_nxt;
  logic                         busy_nxt, done_nxt;
  logic [WORDLEN-1:0]           q_c;
  logic [NW-1:0]                n_start;
  logic                         hs;
  logic                         last_lane;

  assign need      = lane_mask(cfg.n);
  assign n_start   = clamp_lanes(num_lanes);
  assign hs        = valid_q && stream.ready;
  assign last_lane = ({1'b0, p} == (cfg.n - NW'(1)));

  // Single re-quantizer on the lane the stream will present next cycle.
  requant_sat #(
    .RLEN    (RLEN),
    .WORDLEN (WORDLEN),
    .SHW     (SHW)
  ) u_requant (
    .din (bank_nxt[p_nxt]),
    .sh  (cfg_nxt.sh),
    .q_c (q_c)
  );

  assign data_nxt = (enable && (state_nxt == SEND)) ? q_c : data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath and output decode; everything holds while enable is low.
  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    bank_nxt  = bank;
    mask_nxt  = mask;
    ovf_nxt   = ovf;
    p_nxt     = p;

    if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_nxt.n  = n_start;
            cfg_nxt.sh = shift;
            mask_nxt   = '0;
            ovf_nxt    = 1'b0;
            p_nxt      = '0;
            state_nxt  = (n_start == '0) ? FIN : CAPTURE;
          end
        end
        CAPTURE: begin
          // First strobe per lane wins; a repeat only flags overflow.
          for (int i = 0; i < int'(LANES); i++) begin
            if (res_valid[i] && need[i]) begin
              if (mask[i]) begin
                ovf_nxt = 1'b1;
              end else begin
                bank_nxt[i] = res_in[i*RLEN +: RLEN];
                mask_nxt[i] = 1'b1;
              end
            end
          end
          if ((mask_nxt & need) == need) begin
            state_nxt = SEND;
            p_nxt     = '0;
          end
        end
        SEND: begin
          if (hs) begin
            if (last_lane) begin
              state_nxt = FIN;
            end else begin
              p_nxt = p + PW'(1);
            end
          end
        end
        FIN: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    valid_nxt = (state_nxt == SEND);
    busy_nxt  = (state_nxt == CAPTURE) || (state_nxt == SEND);
    done_nxt  = (state_nxt == FIN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cfg     <= '0;
      bank    <= '0;
      mask    <= '0;
      p       <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cfg     <= cfg_nxt;
      bank    <= bank_nxt;
      mask    <= mask_nxt;
      p       <= p_nxt;
      ovf     <= ovf_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  assign stream.data  = data_q;
  assign stream.valid = valid_q;

endmodule

// File: tb/tb_arr_drain_16.sv
// Scoreboard bench for arr_drain_16: directed batches push expected bytes,
// an independent monitor pops and compares on every output handshake.
module tb_arr_drain_16;
  import arr_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  enable = 1'b1;
  logic                  start = 1'b0;
  logic [NW-1:0]         num_lanes = '0;
  logic [SHW-1:0]        shift = '0;
  logic [LANES*RLEN-1:0] res_in = '0;
  logic [LANES-1:0]      res_valid = '0;
  logic                  out_ready = 1'b1;
  logic                  busy, done, ovf;

  arr_drain_16_if u_if ();
  assign u_if.ready = out_ready;

  arr_drain_16 dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .start     (start),
    .num_lanes (num_lanes),
    .shift     (shift),
    .res_in    (res_in),
    .res_valid (res_valid),
    .stream    (u_if),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         hs_cnt = 0;
  int         done_cnt = 0;
  int         first_valid_cyc = -1;
  int         done_cyc = -1;
  int         rdy_mode = 0;
  int         bp_k = 0;
  logic [3:0] bp_pat = 4'b1001;
  bit         stall_prev = 1'b0;
  bit         prev_valid = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ready driver: always-high, or a repeating 1,0,0,1 backpressure pattern.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      out_ready = bp_pat[bp_k % 4];
      bp_k++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: compare every accepted byte against the scoreboard queue.
  always @(negedge clk) begin
    if (rstn) begin
      logic [7:0] e;
      if (u_if.valid && !prev_valid) first_valid_cyc = cyc;
      if (stall_prev)
        chk(u_if.valid && (u_if.data == prev_data), "stall_hold",
            int'($signed(u_if.data)), int'($signed(prev_data)));
      if (u_if.valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", int'($signed(u_if.data)), 0);
        end else begin
          e = exp_q.pop_front();
          chk(u_if.data == e, "byte", int'($signed(u_if.data)), int'($signed(e)));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = u_if.valid && !out_ready;
      prev_data  = u_if.data;
      prev_valid = u_if.valid;
    end else begin
      stall_prev = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input int n, input int sh);
    num_lanes = NW'(n);
    shift     = SHW'(sh);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [15:0] v);
    res_in[i*RLEN +: RLEN] = v;
    res_valid[i]           = 1'b1;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    chk(done_cnt == base + 1, name, done_cnt - base, 1);
    chk(exp_q.size() == 0, {name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int base, hsb, t0, k;

    // Reset values
    rstn = 1'b0;
    tick();
    tick();
    chk(u_if.data == 8'h00, "rst_data", int'(u_if.data), 0);
    chk(u_if.valid == 1'b0, "rst_valid", int'(u_if.valid), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    chk(done == 1'b0, "rst_done", int'(done), 0);
    chk(ovf == 1'b0, "rst_ovf", int'(ovf), 0);
    rstn = 1'b1;
    tick();

    // Skewed full batch: lane i = i-8 strobed at t0+i
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i - 8));
    base = done_cnt; hsb = hs_cnt;
    start_batch(16, 0);
    chk(busy == 1'b1, "busy_after_start", int'(busy), 1);
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      res_valid = '0;
      set_lane(i, 16'(i - 8));
      tick();
    end
    res_valid = '0;
    wait_done(base, 40, "skew_done");
    chk(first_valid_cyc - t0 == 16, "skew_first_byte_cyc", first_valid_cyc - t0, 16);
    chk(done_cyc - t0 == 32, "skew_done_cyc", done_cyc - t0, 32);
    chk(hs_cnt - hsb == 16, "skew_hs_count", hs_cnt - hsb, 16);
    chk(ovf == 1'b0, "skew_ovf", int'(ovf), 0);
    chk(busy == 1'b0, "skew_idle_busy", int'(busy), 0);

    // Saturation with shift 4
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h80);
    base = done_cnt;
    start_batch(2, 4);
    set_lane(0, 16'h7FFF);
    set_lane(1, 16'h8000);
    tick();
    res_valid = '0;
    wait_done(base, 20, "sat_done");

    // In-range shift: 0x0150 -> 21, 0xFEB0 -> -21
    exp_q.push_back(8'd21);
    exp_q.push_back(8'hEB);
    base = done_cnt;
    start_batch(2, 4);
    set_lane(1, 16'hFEB0);
    tick();
    res_valid = '0;
    set_lane(0, 16'h0150);
    tick();
    res_valid = '0;
    wait_done(base, 20, "shift_done");

    // Backpressure
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd30);
    exp_q.push_back(8'd40);
    base = done_cnt; hsb = hs_cnt;
    rdy_mode = 1;
    start_batch(4, 0);
    set_lane(0, 16'd10);
    set_lane(1, 16'd20);
    set_lane(2, 16'd30);
    set_lane(3, 16'd40);
    tick();
    res_valid = '0;
    wait_done(base, 40, "bp_done");
    chk(hs_cnt - hsb == 4, "bp_hs_count", hs_cnt - hsb, 4);
    rdy_mode = 0;
    tick();

    // Partial batch with out-of-range and duplicate strobes
    exp_q.push_back(8'd5);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'd7);
    base = done_cnt; hsb = hs_cnt;
    start_batch(3, 0);
    set_lane(1, 16'h0011);
    set_lane(5, 16'h0055);
    tick();
    res_valid = '0;
    set_lane(1, 16'h0022);
    set_lane(0, 16'h0005);
    tick();
    res_valid = '0;
    set_lane(2, 16'h0007);
    tick();
    res_valid = '0;
    wait_done(base, 20, "dup_done");
    chk(ovf == 1'b1, "dup_ovf", int'(ovf), 1);
    chk(hs_cnt - hsb == 3, "dup_hs_count", hs_cnt - hsb, 3);

    // n = 0: immediate done, no bytes, ovf cleared by the new start
    base = done_cnt; hsb = hs_cnt;
    start_batch(0, 0);
    chk(done == 1'b1, "n0_done_pulse", int'(done), 1);
    chk(busy == 1'b0, "n0_busy", int'(busy), 0);
    chk(ovf == 1'b0, "n0_ovf_cleared", int'(ovf), 0);
    tick();
    chk(done == 1'b0, "n0_done_single", int'(done), 0);
    chk(done_cnt == base + 1, "n0_done_count", done_cnt - base, 1);
    chk(hs_cnt == hsb, "n0_no_bytes", hs_cnt - hsb, 0);

    // n = 20 clamps to 16
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(3 * i));
    base = done_cnt; hsb = hs_cnt;
    start_batch(20, 0);
    for (int i = 0; i < 16; i++) set_lane(i, 16'(3 * i));
    tick();
    res_valid = '0;
    wait_done(base, 40, "n20_done");
    chk(hs_cnt - hsb == 16, "n20_hs_count", hs_cnt - hsb, 16);

    // Reset in the middle of SEND after two bytes
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    base = done_cnt; hsb = hs_cnt;
    start_batch(4, 0);
    for (int i = 0; i < 4; i++) set_lane(i, 16'(i + 1));
    tick();
    res_valid = '0;
    k = 0;
    while (hs_cnt - hsb < 2 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(hs_cnt - hsb == 2, "mid_rst_two_bytes", hs_cnt - hsb, 2);
    rstn = 1'b0;
    tick();
    chk(u_if.valid == 1'b0, "mid_rst_valid", int'(u_if.valid), 0);
    chk(busy == 1'b0, "mid_rst_busy", int'(busy), 0);
    chk(done == 1'b0, "mid_rst_done", int'(done), 0);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk(done_cnt == base, "mid_rst_no_done", done_cnt - base, 0);
    chk(exp_q.size() == 0, "mid_rst_queue", exp_q.size(), 0);

    // Fresh batch after reset
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd65);
    base = done_cnt; hsb = hs_cnt;
    start_batch(2, 0);
    set_lane(0, 16'd64);
    set_lane(1, 16'd65);
    tick();
    res_valid = '0;
    wait_done(base, 20, "post_rst_done");
    chk(hs_cnt - hsb == 2, "post_rst_hs_count", hs_cnt - hsb, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
